// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps sel through channels 0..7, samples y_in
// after a settle delay per channel, and presents the 8 samples as one frame.
module mux8_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic [2:0] sel,
  output logic       sample_en,
  output logic       busy,
  output logic       frame_valid,
  output logic [7:0] frame_data,
  input  logic       frame_ready
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [2:0]       LAST_CH     = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_valid_q, frame_valid_d;
  logic [7:0]       frame_data_q, frame_data_d;
  logic             sample_en_q;
  logic             busy_q;

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;

    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        cnt_d = '0;
        if (start) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        frame_data_d[sel_q] = y_in;
        if (sel_q == LAST_CH) begin
          frame_valid_d = 1'b1;
          state_d       = HOLD;
        end else begin
          sel_d   = sel_q + 3'd1;
          state_d = SETTLE;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          sel_d         = 3'd0;
          cnt_d         = '0;
          // Back-to-back scan skips the IDLE cycle
          state_d       = start ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= 3'd0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= 8'h00;
      sample_en_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      sample_en_q   <= (state_d == SAMPLE);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign sel         = sel_q;
  assign sample_en   = sample_en_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;

endmodule
